// File: rtl/pid_loop_ctrl.sv
// PID loop sequencer: sample tick, measurement handshake,
// error register and clamped actuator command around a PID datapath.
module pid_loop_ctrl #(
  parameter logic signed [15:0] U_MAX = 16'sd1000,
  parameter logic signed [15:0] U_MIN = -16'sd1000
) (
  input  logic               clk,
  input  logic               res,
  input  logic               en,
  input  logic [15:0]        div,
  input  logic signed [15:0] setpoint,
  input  logic signed [15:0] meas,
  input  logic               meas_valid,
  output logic               meas_ready,
  output logic signed [15:0] e_out,
  output logic               pid_step,
  output logic               pid_clr,
  input  logic signed [15:0] u_in,
  output logic signed [15:0] u_out,
  output logic               u_valid,
  output logic               sat,
  output logic               fault
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    WAIT_MEAS,
    STEP,
    UPDATE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [15:0]        cnt;
  logic               tick;
  logic               hs;
  logic               clear;
  logic               miss;
  logic signed [16:0] err;
  logic signed [15:0] err_sat;
  logic signed [15:0] u_clamp;
  logic               u_clip;

  // div is compared live so a new period takes effect at once
  assign tick  = en && (cnt >= div);
  assign hs    = meas_ready && meas_valid;
  assign clear = res || !en;

  // missed sample or overrun of a step in flight
  assign miss = tick && (
    ((state == WAIT_MEAS) && !meas_valid) ||
    (state == STEP) ||
    (state == UPDATE));

  // 17-bit difference cannot overflow; saturate back to 16
  always_comb begin
    err     = {setpoint[15], setpoint} - {meas[15], meas};
    err_sat = err[15:0];
    if (err[16] != err[15])
      err_sat = err[16] ? 16'sh8000 : 16'sh7fff;
  end

  // actuator limit
  always_comb begin
    u_clamp = u_in;
    u_clip  = 1'b0;
    if (u_in > U_MAX) begin
      u_clamp = U_MAX;
      u_clip  = 1'b1;
    end else if (u_in < U_MIN) begin
      u_clamp = U_MIN;
      u_clip  = 1'b1;
    end
  end

  // sample-period counter
  always_ff @(posedge clk) begin
    if (clear)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + 16'd1;
  end

  // state register
  always_ff @(posedge clk) begin
    if (res)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:      state_nx = WAIT_TICK;
        WAIT_TICK: if (tick) state_nx = WAIT_MEAS;
        WAIT_MEAS: if (meas_valid) state_nx = STEP;
        STEP:      state_nx = UPDATE;
        UPDATE:    state_nx = WAIT_TICK;
        default:   state_nx = IDLE;
      endcase
    end
  end

  // strobes; reset overrides so clr and step never overlap
  always_comb begin
    meas_ready = (state == WAIT_MEAS) && en && !res;
    pid_step   = (state == STEP) && !res;
    u_valid    = (state == UPDATE) && !res;
    pid_clr    = (state == IDLE) || res;
  end

  // error register, loaded on the measurement handshake
  always_ff @(posedge clk) begin
    if (clear)
      e_out <= '0;
    else if (hs)
      e_out <= err_sat;
  end

  // actuator command, loaded in the step cycle
  always_ff @(posedge clk) begin
    if (clear) begin
      u_out <= '0;
      sat   <= 1'b0;
    end else if (state == STEP) begin
      u_out <= u_clamp;
      sat   <= u_clip;
    end
  end

  // sticky fault until disabled or reset
  always_ff @(posedge clk) begin
    if (clear)
      fault <= 1'b0;
    else if (miss)
      fault <= 1'b1;
  end

endmodule

// File: tb/tb_pid_loop_ctrl.sv
// Bench for pid_loop_ctrl: cycle model compared every cycle
// plus directed literal checks.
module tb_pid_loop_ctrl;

  localparam int UMAX = 1000;
  localparam int UMIN = -1000;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic en = 1'b0;
  logic [15:0] div = 16'd9;
  logic signed [15:0] setpoint = '0;
  logic signed [15:0] meas = '0;
  logic meas_valid = 1'b0;
  logic signed [15:0] u_in = '0;

  logic meas_ready;
  logic signed [15:0] e_out;
  logic pid_step;
  logic pid_clr;
  logic signed [15:0] u_out;
  logic u_valid;
  logic sat;
  logic fault;

  pid_loop_ctrl dut (
    .clk(clk),
    .res(res),
    .en(en),
    .div(div),
    .setpoint(setpoint),
    .meas(meas),
    .meas_valid(meas_valid),
    .meas_ready(meas_ready),
    .e_out(e_out),
    .pid_step(pid_step),
    .pid_clr(pid_clr),
    .u_in(u_in),
    .u_out(u_out),
    .u_valid(u_valid),
    .sat(sat),
    .fault(fault)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // model: running?, waiting for sample?, cycles into a step
  int m_cnt = 0;
  bit m_run = 1'b0;
  bit m_armed = 1'b0;
  int m_pipe = 0;
  int m_e = 0;
  int m_u = 0;
  bit m_sat = 1'b0;
  bit m_fault = 1'b0;

  function automatic int sat16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  always @(posedge clk) begin
    bit tk;
    tk = en && (m_cnt >= int'(div));
    if (res || !en) begin
      m_cnt = 0; m_run = 0; m_armed = 0; m_pipe = 0;
      m_e = 0; m_u = 0; m_sat = 0; m_fault = 0;
    end else begin
      m_cnt = tk ? 0 : m_cnt + 1;
      if (!m_run) begin
        m_run = 1;
      end else if (m_pipe == 1) begin
        if (int'(u_in) > UMAX) begin
          m_u = UMAX; m_sat = 1;
        end else if (int'(u_in) < UMIN) begin
          m_u = UMIN; m_sat = 1;
        end else begin
          m_u = int'(u_in); m_sat = 0;
        end
        m_pipe = 2;
        if (tk) m_fault = 1;
      end else if (m_pipe == 2) begin
        m_pipe = 0;
        if (tk) m_fault = 1;
      end else if (m_armed) begin
        if (meas_valid) begin
          m_e = sat16(int'(setpoint) - int'(meas));
          m_armed = 0;
          m_pipe = 1;
        end else if (tk) begin
          m_fault = 1;
        end
      end else if (tk) begin
        m_armed = 1;
      end
    end
  end

  always @(negedge clk) begin
    bit x_rdy, x_stp, x_clr, x_uv;
    if (chk_on) begin
      x_rdy = m_run && m_armed && en && !res;
      x_stp = (m_pipe == 1) && !res;
      x_uv  = (m_pipe == 2) && !res;
      x_clr = !m_run || res;
      n_vec++;
      if (meas_ready !== x_rdy || pid_step !== x_stp ||
          pid_clr !== x_clr || u_valid !== x_uv ||
          int'(e_out) != m_e || int'(u_out) != m_u ||
          sat !== m_sat || fault !== m_fault) begin
        n_bad++;
        $display("FAIL model t=%0t got rdy%b stp%b clr%b uv%b e%0d u%0d s%b f%b req rdy%b stp%b clr%b uv%b e%0d u%0d s%b f%b",
          $time, meas_ready, pid_step, pid_clr, u_valid,
          e_out, u_out, sat, fault, x_rdy, x_stp, x_clr,
          x_uv, m_e, m_u, m_sat, m_fault);
      end
    end
  end

  task automatic chk(input string name, input int got, input int req);
    n_vec++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s got %0d req %0d", name, got, req);
    end
  endtask

  task automatic wait_step(input int maxc, output int n);
    bit ok;
    ok = 0;
    n = 0;
    while (!ok && n < maxc) begin
      @(negedge clk);
      n++;
      if (pid_step === 1'b1) ok = 1;
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL step_timeout got none req pid_step in %0d", maxc);
    end
  endtask

  initial begin
    int n;
    bit seen;
    @(posedge clk);
    #1 chk_on = 1;
    @(negedge clk);
    chk("rst_u", int'(u_out), 0);
    chk("rst_clr", int'(pid_clr), 1);
    chk("rst_rdy", int'(meas_ready), 0);

    // steady loop, div=9
    @(posedge clk); #1;
    res = 0; en = 1; div = 9; meas_valid = 1;
    setpoint = 100; meas = 30; u_in = -200;
    wait_step(40, n);
    chk("e_70", int'(e_out), 70);
    @(negedge clk);
    chk("u_m200", int'(u_out), -200);
    chk("sat_0", int'(sat), 0);
    chk("uv_1", int'(u_valid), 1);
    wait_step(20, n);
    chk("period", n, 9);
    chk("flt_0", int'(fault), 0);

    // upper clamp
    @(posedge clk); #1 u_in = 5000;
    wait_step(20, n);
    @(negedge clk);
    chk("u_1000", int'(u_out), 1000);
    chk("sat_1", int'(sat), 1);

    // error saturation both ways, lower clamp
    @(posedge clk); #1;
    setpoint = -32768; meas = 32767; u_in = -1500;
    wait_step(20, n);
    chk("e_min", int'(e_out), -32768);
    @(negedge clk);
    chk("u_m1000", int'(u_out), -1000);
    @(posedge clk); #1;
    setpoint = 32767; meas = -32768;
    wait_step(20, n);
    chk("e_max", int'(e_out), 32767);

    // missing measurement, div=4
    @(posedge clk); #1 en = 0;
    @(posedge clk); #1;
    div = 4; meas_valid = 0; en = 1;
    setpoint = 5; meas = 8;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (pid_step === 1'b1) seen = 1;
    end
    chk("miss_flt", int'(fault), 1);
    chk("miss_nostep", int'(seen), 0);
    @(posedge clk); #1 meas_valid = 1;
    wait_step(20, n);
    chk("late_e", int'(e_out), -3);
    chk("late_flt", int'(fault), 1);

    // overrun, div=1, then drop en
    @(posedge clk); #1 en = 0;
    @(posedge clk); #1;
    div = 1; meas_valid = 1; en = 1;
    repeat (10) @(negedge clk);
    chk("ovr_flt", int'(fault), 1);
    @(posedge clk); #1 en = 0;
    @(posedge clk);
    @(negedge clk);
    chk("dis_flt", int'(fault), 0);
    chk("dis_u", int'(u_out), 0);
    chk("dis_clr", int'(pid_clr), 1);
    chk("dis_e", int'(e_out), 0);

    // reset in the step cycle
    @(posedge clk); #1;
    div = 9; meas_valid = 1; en = 1; u_in = 300;
    wait_step(40, n);
    wait_step(20, n);
    #2 res = 1;
    @(posedge clk);
    @(negedge clk);
    chk("r_uv", int'(u_valid), 0);
    chk("r_stp", int'(pid_step), 0);
    chk("r_u", int'(u_out), 0);
    chk("r_clr", int'(pid_clr), 1);
    chk("r_rdy", int'(meas_ready), 0);
    @(posedge clk); #1 res = 0;
    repeat (25) @(negedge clk);

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_bad);
    $finish;
  end

endmodule
